// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: streams a writable table of codec control words to an I2C master.
// Define CFG_RETRY_EN to resend NACKed entries up to MAX_RETRY times before reporting an error.
module codec_cfg_sequencer #(
   parameter int NUM_REGS   = 12,
   parameter int DATA_W     = 16,
   parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   parameter int MAX_RETRY  = 3,
   parameter int TIMEOUT    = 4095,
   parameter int GAP_CYCLES = 8
) (
   input  logic              clk_i2c,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              start_cf_i,
   input  logic [IDX_W:0]    num_regs_i,
   input  logic              tbl_we_i,
   input  logic [IDX_W-1:0]  tbl_waddr_i,
   input  logic [DATA_W-1:0] tbl_wdata_i,
   input  logic              i2c_busy_i,
   input  logic              i2c_done_i,
   input  logic              i2c_nack_i,
   output logic              send_start_i2c_o,
   output logic [DATA_W-1:0] cf_data_o,
   output logic [IDX_W-1:0]  cf_index_o,
   output logic              cf_busy_o,
   output logic              cf_done_o,
   output logic              cf_err_o,
   output logic [1:0]        retry_cnt_o
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int RW = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);
   localparam logic [IDX_W:0] NMAX = (IDX_W + 1)'(NUM_REGS);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_GAP, S_DONE, S_ERR} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    index_q, index_d;
   logic [IDX_W:0]      n_q, n_d;
   logic [RW-1:0]       retry_q, retry_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [DATA_W-1:0]   tbl_q [NUM_REGS];
   logic                ready, retry_left, last;
   logic [IDX_W:0]      n_clamp;

   assign ready   = (state_q == S_IDLE) || (state_q == S_ERR);
   assign n_clamp = (num_regs_i > NMAX) ? NMAX : num_regs_i;
   assign last    = ({1'b0, index_q} + 1'b1) == n_q;
`ifdef CFG_RETRY_EN
   assign retry_left = retry_q < RW'(MAX_RETRY);
`else
   assign retry_left = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      n_d     = n_q;
      retry_d = retry_q;
      tmo_d   = tmo_q;
      gap_d   = gap_q;
      if (en_i) begin
         case (state_q)
            S_IDLE, S_ERR: begin
               if (start_cf_i && !i2c_busy_i) begin
                  n_d     = n_clamp;
                  index_d = '0;
                  retry_d = '0;
                  state_d = (n_clamp == '0) ? S_DONE : S_SEND;
               end
            end
            S_SEND: begin
               tmo_d   = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (i2c_done_i && !i2c_nack_i) begin
                  if (last) state_d = S_DONE;
                  else begin
                     index_d = index_q + 1'b1;
                     retry_d = '0;
                     gap_d   = '0;
                     state_d = S_GAP;
                  end
               end else if (i2c_done_i) begin
                  // NACK: resend the same entry after a gap while retries remain
                  if (retry_left) begin
                     retry_d = retry_q + 1'b1;
                     gap_d   = '0;
                     state_d = S_GAP;
                  end else state_d = S_ERR;
               end else if (tmo_q == TW'(TIMEOUT - 1)) state_d = S_ERR;
               else tmo_d = tmo_q + 1'b1;
            end
            S_GAP: begin
               if (!i2c_busy_i) begin
                  if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_SEND;
                  else gap_d = gap_q + 1'b1;
               end
            end
            S_DONE: begin
               index_d = '0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i2c) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         index_q <= '0;
         n_q     <= '0;
         retry_q <= '0;
         tmo_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         n_q     <= n_d;
         retry_q <= retry_d;
         tmo_q   <= tmo_d;
         gap_q   <= gap_d;
      end
   end

   always_ff @(posedge clk_i2c) begin
      if (tbl_we_i && ready && ({1'b0, tbl_waddr_i} < NMAX)) tbl_q[tbl_waddr_i] <= tbl_wdata_i;
   end

   assign send_start_i2c_o = en_i && (state_q == S_SEND);
   assign cf_done_o        = en_i && (state_q == S_DONE);
   assign cf_busy_o        = !ready;
   assign cf_err_o         = state_q == S_ERR;
   assign cf_index_o       = index_q;
   assign cf_data_o        = tbl_q[index_q];
   assign retry_cnt_o      = (retry_q > RW'(3)) ? 2'd3 : retry_q[1:0];
endmodule
